cart_flash_arbiter: RTL and testbench
=====================================

Name: cart_flash_arbiter

Overview:
Shares the single asynchronous cartridge flash port between two requesters: port 0 (CPU cartridge ROM fetch path) and port 1 (DMA / boot-copy engine).
- Sequences each flash access: address phase, fixed wait-state window, data capture, one-cycle acknowledge.
- Arbitrates round-robin when both ports request.
- Sits between the cartridge/MBC logic and the board flash pins. It owns O_FLASH_ADDR and all flash control strobes.

Parameters:
WAIT_CYCLES, 4, flash access wait states after the address phase; legal range 1..15.
ADDR_W, 24, flash word-address width.

Ports:
I_CLK  input  1  system clock
I_RESET  input  1  reset, asynchronous, active-high
I_P0_REQ  input  1  port 0 (CPU) read request, level
I_P0_ADDR  input  ADDR_W  port 0 flash word address
O_P0_ACK  output  1  port 0 data-valid pulse
O_P0_DATA  output  16  port 0 read data
I_P1_REQ  input  1  port 1 (DMA) read request, level
I_P1_ADDR  input  ADDR_W  port 1 flash word address
O_P1_ACK  output  1  port 1 data-valid pulse
O_P1_DATA  output  16  port 1 read data
I_FLASH_DATA  input  16  flash data bus
O_FLASH_ADDR  output  ADDR_W  flash address, registered
O_FLASH_CLK  output  1  tied 1 (asynchronous read mode)
O_ADDR_VALID_L  output  1  low during address phase only
O_FLASH_CE_L  output  1  low while an access is in flight
O_FLASH_OE_L  output  1  low while an access is in flight
O_FLASH_WE_L  output  1  tied 1 (read-only)
O_BUSY  output  1  high when state is not IDLE

Behaviour:
- Reset is asynchronous on I_RESET high:
  - state IDLE, wait counter 0, last_grant=1 (so port 0 wins first tie);
  - O_FLASH_ADDR=0, O_Px_ACK=0, O_Px_DATA=0;
  - O_ADDR_VALID_L=1, O_FLASH_CE_L=1, O_FLASH_OE_L=1, O_BUSY=0.
- States: IDLE, ADDR, WAIT.
- IDLE:
  - A port is eligible if its REQ=1 and its ACK is not currently high. The ACK mask stops a requester that is still holding REQ during its ack cycle from being re-granted.
  - One eligible port: grant it.
  - Both eligible: grant the port != last_grant.
  - On grant:
    - register grant and last_grant;
    - register O_FLASH_ADDR from the granted port's ADDR;
    - go to ADDR.
  - No eligible port: stay in IDLE; O_FLASH_ADDR holds its last value.
- ADDR (exactly 1 cycle): O_ADDR_VALID_L=0, CE_L=0, OE_L=0. Next state WAIT, counter=0.
- WAIT:
  - CE_L=0, OE_L=0, ADDR_VALID_L=1; counter increments each cycle.
  - On the edge where counter==WAIT_CYCLES-1:
    - capture I_FLASH_DATA into O_Px_DATA of the granted port only;
    - assert that port's O_Px_ACK for exactly one cycle;
    - go to IDLE.
- Latency: REQ sampled at edge k, then ACK is high during cycle k+1+WAIT_CYCLES (ACK rises at edge k+1+WAIT_CYCLES). With the default, that is edge k+5.
- Throughput: one access per WAIT_CYCLES+2 cycles when back-to-back. The IDLE cycle overlaps the previous ACK.
- O_Px_DATA holds its value until that port's next ACK. The other port's DATA is never modified.
- O_FLASH_ADDR is stable from the ADDR cycle until the next grant. Requester ADDR changes after grant are ignored.
- REQ dropped mid-access: the access completes and ACK still pulses; the requester ignores it. No abort.
- REQ is level-sensitive. A requester must deassert REQ, or change ADDR for a new read, on the edge it samples ACK=1.
- Reset asserted mid-ADDR/WAIT: immediate return to reset values. No ACK is issued for the aborted access.
- O_FLASH_CLK and O_FLASH_WE_L are constant 1 at all times, including during reset.

Test Plan:
- Single port-0 read, WAIT_CYCLES=4, I_P0_ADDR=24'h004123, flash model returns 16'hBEEF with 3-cycle access:
  - O_ADDR_VALID_L low 1 cycle;
  - O_P0_ACK high exactly 5 edges after REQ was sampled;
  - O_P0_DATA=16'hBEEF;
  - O_P1_DATA stays 0.
- Both REQ held high continuously from reset, addresses 0x10 and 0x20:
  - grants alternate P0, P1, P0, P1;
  - O_FLASH_ADDR sequence 0x10, 0x20, 0x10, 0x20;
  - one access every 6 cycles.
- Port 1 alone, REQ held through its ACK cycle then dropped:
  - exactly one access is issued;
  - no second ADDR phase is started during the ACK cycle.
- Port 0 changes I_P0_ADDR from 0x100 to 0x200 during WAIT:
  - O_FLASH_ADDR stays 0x100;
  - data captured is from 0x100.
- I_RESET pulsed during the WAIT state:
  - all outputs go to reset values asynchronously;
  - no ACK appears;
  - the next request after release completes normally, with port 0 winning a tie.
- WAIT_CYCLES=1 build, back-to-back port-0 reads:
  - ACK two edges after each grant;
  - 3-cycle access period.

Source files
------------

// File: rtl/cart_flash_arbiter.sv
// Round-robin arbiter sharing the asynchronous cartridge flash read port between the
// CPU fetch path (port 0) and the DMA/boot-copy engine (port 1).
module cart_flash_arbiter #(
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_W      = 24
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  input  logic              I_P0_REQ,
  input  logic [ADDR_W-1:0] I_P0_ADDR,
  output logic              O_P0_ACK,
  output logic [15:0]       O_P0_DATA,
  input  logic              I_P1_REQ,
  input  logic [ADDR_W-1:0] I_P1_ADDR,
  output logic              O_P1_ACK,
  output logic [15:0]       O_P1_DATA,
  input  logic [15:0]       I_FLASH_DATA,
  output logic [ADDR_W-1:0] O_FLASH_ADDR,
  output logic              O_FLASH_CLK,
  output logic              O_ADDR_VALID_L,
  output logic              O_FLASH_CE_L,
  output logic              O_FLASH_OE_L,
  output logic              O_FLASH_WE_L,
  output logic              O_BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [15:0]       p0_data_q, p0_data_d;
  logic [15:0]       p1_data_q, p1_data_d;
  logic              elig0, elig1, pick;

  // A port still holding REQ while its ACK is high must not be served twice.
  assign elig0 = I_P0_REQ & ~p0_ack_q;
  assign elig1 = I_P1_REQ & ~p1_ack_q;
  assign pick  = (elig0 & elig1) ? ~last_grant_q : elig1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_data_d    = p0_data_q;
    p1_data_d    = p1_data_q;
    case (state_q)
      ST_IDLE: begin
        if (elig0 | elig1) begin
          grant_d      = pick;
          last_grant_d = pick;
          addr_d       = pick ? I_P1_ADDR : I_P0_ADDR;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_d   = 4'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          // Data is captured on the same edge that raises the ACK pulse.
          if (grant_q) begin
            p1_data_d = I_FLASH_DATA;
            p1_ack_d  = 1'b1;
          end else begin
            p0_data_d = I_FLASH_DATA;
            p0_ack_d  = 1'b1;
          end
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_data_q    <= 16'h0000;
      p1_data_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_data_q    <= p0_data_d;
      p1_data_q    <= p1_data_d;
    end
  end

  assign O_FLASH_ADDR   = addr_q;
  assign O_FLASH_CLK    = 1'b1;
  assign O_FLASH_WE_L   = 1'b1;
  assign O_ADDR_VALID_L = (state_q != ST_ADDR);
  assign O_FLASH_CE_L   = (state_q == ST_IDLE);
  assign O_FLASH_OE_L   = (state_q == ST_IDLE);
  assign O_BUSY         = (state_q != ST_IDLE);
  assign O_P0_ACK       = p0_ack_q;
  assign O_P1_ACK       = p1_ack_q;
  assign O_P0_DATA      = p0_data_q;
  assign O_P1_DATA      = p1_data_q;

endmodule

// File: tb/tb_cart_flash_arbiter.sv
// Bench for cart_flash_arbiter: table vectors, directed corner sequences and random
// two-port traffic checked every cycle against a transaction-timeline model.
module tb_cart_flash_arbiter;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // DUT A: default build
  logic        a_p0_req = 1'b0, a_p1_req = 1'b0;
  logic [23:0] a_p0_addr = 24'h0, a_p1_addr = 24'h0;
  logic        a_ack0, a_ack1;
  logic [15:0] a_d0, a_d1, a_fdata;
  logic [23:0] a_faddr;
  logic        a_fclk, a_valid_l, a_ce_l, a_oe_l, a_we_l, a_busy;

  // DUT B: WAIT_CYCLES=1 build
  logic        b_p0_req = 1'b0, b_p1_req = 1'b0;
  logic [23:0] b_p0_addr = 24'h0, b_p1_addr = 24'h0;
  logic        b_ack0, b_ack1;
  logic [15:0] b_d0, b_d1, b_fdata;
  logic [23:0] b_faddr;
  logic        b_fclk, b_valid_l, b_ce_l, b_oe_l, b_we_l, b_busy;

  cart_flash_arbiter #(.WAIT_CYCLES(W), .ADDR_W(24)) dut_a (
    .I_CLK(clk), .I_RESET(rst),
    .I_P0_REQ(a_p0_req), .I_P0_ADDR(a_p0_addr), .O_P0_ACK(a_ack0), .O_P0_DATA(a_d0),
    .I_P1_REQ(a_p1_req), .I_P1_ADDR(a_p1_addr), .O_P1_ACK(a_ack1), .O_P1_DATA(a_d1),
    .I_FLASH_DATA(a_fdata), .O_FLASH_ADDR(a_faddr), .O_FLASH_CLK(a_fclk),
    .O_ADDR_VALID_L(a_valid_l), .O_FLASH_CE_L(a_ce_l), .O_FLASH_OE_L(a_oe_l),
    .O_FLASH_WE_L(a_we_l), .O_BUSY(a_busy)
  );

  cart_flash_arbiter #(.WAIT_CYCLES(1), .ADDR_W(24)) dut_b (
    .I_CLK(clk), .I_RESET(rst),
    .I_P0_REQ(b_p0_req), .I_P0_ADDR(b_p0_addr), .O_P0_ACK(b_ack0), .O_P0_DATA(b_d0),
    .I_P1_REQ(b_p1_req), .I_P1_ADDR(b_p1_addr), .O_P1_ACK(b_ack1), .O_P1_DATA(b_d1),
    .I_FLASH_DATA(b_fdata), .O_FLASH_ADDR(b_faddr), .O_FLASH_CLK(b_fclk),
    .O_ADDR_VALID_L(b_valid_l), .O_FLASH_CE_L(b_ce_l), .O_FLASH_OE_L(b_oe_l),
    .O_FLASH_WE_L(b_we_l), .O_BUSY(b_busy)
  );

  function automatic logic [15:0] mem(input logic [23:0] a);
    if (a == 24'h004123) return 16'hBEEF;
    return (a[15:0] * 16'd3) ^ 16'h5A5A ^ {8'h00, a[23:16]};
  endfunction

  // Flash A: data valid 3 cycles after the address phase, garbage before that.
  logic [3:0] acc_cnt = 4'd15;
  always @(posedge clk) begin
    if (!a_valid_l)            acc_cnt <= 4'd1;
    else if (acc_cnt != 4'd15) acc_cnt <= acc_cnt + 4'd1;
  end
  assign a_fdata = (acc_cnt >= 4'd3) ? mem(a_faddr) : ~mem(a_faddr);
  assign b_fdata = mem(b_faddr);

  int n_checks = 0;
  int n_err    = 0;
  int edge_n   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: an access granted at edge g acks at edge g+W+1 and frees the
  // port for a new grant at the following edge.
  logic        m_busy, m_gport, m_last, m_ack0, m_ack1;
  logic [23:0] m_gaddr, m_faddr;
  logic [15:0] m_d0, m_d1;
  int          m_gedge;

  task automatic model_reset();
    m_busy = 0; m_gport = 0; m_last = 1; m_ack0 = 0; m_ack1 = 0;
    m_gaddr = 0; m_faddr = 0; m_d0 = 0; m_d1 = 0; m_gedge = 0;
  endtask

  task automatic model_edge(input logic r0, input logic [23:0] a0,
                            input logic r1, input logic [23:0] a1);
    logic pa0, pa1, e0, e1, port;
    pa0 = m_ack0; pa1 = m_ack1;
    m_ack0 = 0; m_ack1 = 0;
    if (m_busy) begin
      if (edge_n == m_gedge + W + 1) begin
        m_busy = 0;
        if (m_gport) begin m_ack1 = 1; m_d1 = mem(m_gaddr); end
        else         begin m_ack0 = 1; m_d0 = mem(m_gaddr); end
        $display("txn A: port%0d addr=%h data=%h edge=%0d", m_gport, m_gaddr, mem(m_gaddr), edge_n);
      end
    end else begin
      e0 = r0 && !pa0;
      e1 = r1 && !pa1;
      if (e0 || e1) begin
        port    = (e0 && e1) ? !m_last : e1;
        m_last  = port;
        m_gport = port;
        m_gaddr = port ? a1 : a0;
        m_faddr = m_gaddr;
        m_busy  = 1;
        m_gedge = edge_n;
      end
    end
  endtask

  task automatic compare_a();
    chk("a_ack0", 32'(a_ack0), 32'(m_ack0));
    chk("a_ack1", 32'(a_ack1), 32'(m_ack1));
    chk("a_data0", 32'(a_d0), 32'(m_d0));
    chk("a_data1", 32'(a_d1), 32'(m_d1));
    chk("a_flash_addr", 32'(a_faddr), 32'(m_faddr));
    chk("a_busy", 32'(a_busy), 32'(m_busy));
    chk("a_addr_valid_l", 32'(a_valid_l), 32'(!(m_busy && m_gedge == edge_n)));
    chk("a_ce_l", 32'(a_ce_l), 32'(!m_busy));
    chk("a_oe_l", 32'(a_oe_l), 32'(!m_busy));
    chk("a_flash_clk", 32'(a_fclk), 32'd1);
    chk("a_we_l", 32'(a_we_l), 32'd1);
    chk("b_flash_clk", 32'(b_fclk), 32'd1);
    chk("b_we_l", 32'(b_we_l), 32'd1);
  endtask

  task automatic step();
    logic r0, r1, rs;
    logic [23:0] a0, a1;
    r0 = a_p0_req; r1 = a_p1_req; a0 = a_p0_addr; a1 = a_p1_addr; rs = rst;
    @(posedge clk);
    edge_n++;
    if (rs) model_reset();
    else    model_edge(r0, a0, r1, a1);
    #1;
    compare_a();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_a();
    chk("b_busy_rst", 32'(b_busy), 32'd0);
    chk("b_faddr_rst", 32'(b_faddr), 32'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int max_steps, output int n, output int nvalid, output logic got);
    n = 0; nvalid = 0; got = 0;
    while (!got && n < max_steps) begin
      step();
      n++;
      if (!a_valid_l) nvalid++;
      if (a_ack0 || a_ack1) got = 1;
    end
    chk("ack_timeout", 32'(got), 32'd1);
  endtask

  typedef struct {
    logic        r0;
    logic [23:0] a0;
    logic        r1;
    logic [23:0] a1;
    logic        exp_port;
    logic [23:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t        vecs[6];
  int          n, nv, ng, nph, bg, back, b_last_g;
  logic        got;
  int          gedge[4];
  logic [23:0] gaddr[4];
  logic [23:0] b_gaddr;
  int          idle0, idle1;
  logic        hold0, hold1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 24'h004123, 1'b0, 24'h000000, 1'b0, 24'h004123, 16'hBEEF};
    vecs[1] = '{1'b0, 24'h000000, 1'b1, 24'h000055, 1'b1, 24'h000055, mem(24'h000055)};
    vecs[2] = '{1'b1, 24'h000010, 1'b1, 24'h000020, 1'b0, 24'h000010, mem(24'h000010)};
    vecs[3] = '{1'b1, 24'h000030, 1'b1, 24'h000040, 1'b1, 24'h000040, mem(24'h000040)};
    vecs[4] = '{1'b1, 24'hFFFFFF, 1'b0, 24'h000000, 1'b0, 24'hFFFFFF, mem(24'hFFFFFF)};
    vecs[5] = '{1'b1, 24'h000007, 1'b1, 24'h000008, 1'b1, 24'h000008, mem(24'h000008)};

    do_reset();

    // Table: each vector starts from idle and runs one access to its ack.
    for (int i = 0; i < 6; i++) begin
      a_p0_req = vecs[i].r0; a_p0_addr = vecs[i].a0;
      a_p1_req = vecs[i].r1; a_p1_addr = vecs[i].a1;
      wait_ack(12, n, nv, got);
      chk("vec_latency", 32'(n - 1), 32'(W + 1));
      chk("vec_port", 32'(a_ack1), 32'(vecs[i].exp_port));
      chk("vec_flash_addr", 32'(a_faddr), 32'(vecs[i].exp_addr));
      chk("vec_data", 32'(a_ack1 ? a_d1 : a_d0), 32'(vecs[i].exp_data));
      chk("vec_addr_phase_cycles", 32'(nv), 32'd1);
      if (i == 0) chk("p1_data_untouched", 32'(a_d1), 32'd0);
      a_p0_req = 0; a_p1_req = 0;
      step(); step();
    end

    // Both ports held from reset: strict alternation, one grant every W+2 cycles.
    do_reset();
    a_p0_req = 1; a_p0_addr = 24'h10; a_p1_req = 1; a_p1_addr = 24'h20;
    ng = 0;
    for (int s = 0; s < 40 && ng < 4; s++) begin
      step();
      if (!a_valid_l) begin gedge[ng] = edge_n; gaddr[ng] = a_faddr; ng++; end
    end
    chk("rr_grant_count", 32'(ng), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_addr_seq", 32'(gaddr[k]), (k % 2 == 1) ? 32'h20 : 32'h10);
      if (k > 0) chk("rr_period", 32'(gedge[k] - gedge[k-1]), 32'(W + 2));
    end
    a_p0_req = 0; a_p1_req = 0;
    repeat (8) step();

    // Port 1 keeps REQ through its ack cycle: still only one access.
    a_p1_req = 1; a_p1_addr = 24'h0055AA;
    wait_ack(12, n, nph, got);
    step();
    if (!a_valid_l) nph++;
    a_p1_req = 0;
    for (int s = 0; s < 8; s++) begin
      step();
      if (!a_valid_l) nph++;
    end
    chk("p1_hold_single_access", 32'(nph), 32'd1);

    // Requester address change after grant is ignored.
    a_p0_req = 1; a_p0_addr = 24'h000100;
    step(); step(); step();
    a_p0_addr = 24'h000200;
    wait_ack(12, n, nv, got);
    chk("addr_change_flash_addr", 32'(a_faddr), 32'h100);
    chk("addr_change_data", 32'(a_d0), 32'(mem(24'h000100)));
    a_p0_req = 0;
    step(); step();

    // Reset in the middle of WAIT: aborted access, then port 0 wins the next tie.
    a_p0_req = 1; a_p0_addr = 24'h000321;
    step(); step(); step();
    chk("pre_reset_busy", 32'(a_busy), 32'd1);
    a_p0_req = 0;
    do_reset();
    a_p0_req = 1; a_p0_addr = 24'h000011; a_p1_req = 1; a_p1_addr = 24'h000022;
    wait_ack(12, n, nv, got);
    chk("post_reset_tie_port", 32'(a_ack1), 32'd0);
    chk("post_reset_data", 32'(a_d0), 32'(mem(24'h000011)));
    a_p0_req = 0; a_p1_req = 0;
    step(); step();

    // WAIT_CYCLES=1 build: ack two edges after grant; port 0 re-reads continuously
    // and the other port fills its masked ack cycle, giving a 3-cycle cadence.
    b_p0_req = 1; b_p0_addr = 24'h001000; b_p1_req = 1; b_p1_addr = 24'h002000;
    bg = 0; back = 0; b_last_g = 0; b_gaddr = 0;
    for (int s = 0; s < 40 && back < 6; s++) begin
      step();
      if (!b_valid_l) begin
        if (bg > 0) chk("b_grant_period", 32'(edge_n - b_last_g), 32'd3);
        b_gaddr = (bg % 2 == 1) ? b_p1_addr : b_p0_addr;
        chk("b_grant_addr", 32'(b_faddr), 32'(b_gaddr));
        b_last_g = edge_n;
        bg++;
      end
      if (b_ack0 || b_ack1) begin
        chk("b_ack_latency", 32'(edge_n - b_last_g), 32'd2);
        chk("b_ack_port", 32'(b_ack1), 32'((bg - 1) % 2));
        chk("b_data", 32'(b_ack1 ? b_d1 : b_d0), 32'(mem(b_gaddr)));
        $display("txn B: port%0d addr=%h data=%h edge=%0d", b_ack1, b_gaddr, b_ack1 ? b_d1 : b_d0, edge_n);
        back++;
        if (b_ack0) b_p0_addr = b_p0_addr + 24'd1;
        else        b_p1_addr = b_p1_addr + 24'd1;
      end
    end
    chk("b_ack_count", 32'(back), 32'd6);
    b_p0_req = 0; b_p1_req = 0;
    repeat (4) step();

    // Random two-port traffic; requesters release on ack or one cycle later.
    idle0 = 0; idle1 = 0; hold0 = 0; hold1 = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (hold0) begin
        a_p0_req = 0; hold0 = 0; idle0 = $urandom_range(0, 3);
      end else if (m_ack0) begin
        if ($urandom_range(0, 1) == 1) hold0 = 1;
        else begin a_p0_req = 0; idle0 = $urandom_range(0, 3); end
      end else if (!a_p0_req) begin
        if (idle0 == 0) begin a_p0_req = 1; a_p0_addr = 24'($urandom()); end
        else idle0--;
      end
      if (hold1) begin
        a_p1_req = 0; hold1 = 0; idle1 = $urandom_range(0, 3);
      end else if (m_ack1) begin
        if ($urandom_range(0, 1) == 1) hold1 = 1;
        else begin a_p1_req = 0; idle1 = $urandom_range(0, 3); end
      end else if (!a_p1_req) begin
        if (idle1 == 0) begin a_p1_req = 1; a_p1_addr = 24'($urandom()); end
        else idle1--;
      end
    end
    a_p0_req = 0; a_p1_req = 0;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
